diffusion_layer_seq: RTL and testbench

DIFFUSION_LAYER_SEQ -- requirements
Module: diffusion_layer_seq

---
 rtl/diffusion_layer_seq.sv | 159 +++++++++++++++
 tb/tb_diffusion_layer_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/diffusion_layer_seq.sv
// Ascon linear diffusion layer with a sequential, lane-parallel datapath.
// A request is latched into a working register, transformed LANES words per
// cycle under a small IDLE/BUSY/DONE handshake FSM, and presented on
// diffusion_o until the downstream side accepts it.

package ascon_pack;
    // Five 64-bit state words; index 0 is x0, index 4 is x4.
    typedef logic [4:0][63:0] type_state;
endpackage

module diffusion_layer_seq
    import ascon_pack::*;
#(
    parameter int LANES   = 5,
    parameter int REG_OUT = 1
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  logic      bypass_i,
    input  type_state diffusion_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state diffusion_o
);

    // Reject unsupported lane counts at elaboration time.
    generate
        if ((LANES < 1) || (LANES > 5)) begin : g_bad_lanes
            $error("diffusion_layer_seq: LANES must be in the range 1..5");
        end
    endgenerate

    localparam logic [3:0] LANES_W     = 4'(LANES);
    localparam logic [3:0] WORDS_W     = 4'd5;
    localparam bit         USE_OUT_REG = (REG_OUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rotate right by a constant amount, modulo 64 (no width growth).
    function automatic logic [63:0] rotr(input logic [63:0] x, input logic [5:0] n);
        return (x >> n) | (x << (7'd64 - {1'b0, n}));
    endfunction

    // Per-word linear diffusion with the Ascon rotation pairs.
    function automatic logic [63:0] sigma(input logic [2:0] idx, input logic [63:0] x);
        logic [63:0] y;
        case (idx)
            3'd0:    y = x ^ rotr(x, 6'd19) ^ rotr(x, 6'd28);
            3'd1:    y = x ^ rotr(x, 6'd61) ^ rotr(x, 6'd39);
            3'd2:    y = x ^ rotr(x, 6'd1)  ^ rotr(x, 6'd6);
            3'd3:    y = x ^ rotr(x, 6'd10) ^ rotr(x, 6'd17);
            3'd4:    y = x ^ rotr(x, 6'd7)  ^ rotr(x, 6'd41);
            default: y = x;
        endcase
        return y;
    endfunction

    state_t     state_r;
    logic [3:0] ptr_r;
    type_state  work_r;
    logic       bypass_r;
    type_state  out_r;
    logic       valid_r;
    logic       ready_r;

    type_state  next_work_s;
    logic [3:0] ptr_next_s;
    logic       last_pass_s;

    // The pass covers words ptr..ptr+LANES-1; words at index 5 and above do not exist.
    assign ptr_next_s  = ptr_r + LANES_W;
    assign last_pass_s = (ptr_next_s >= WORDS_W);

    // Transform the words covered by the current pass; all other words are kept.
    always_comb begin
        next_work_s = work_r;
        for (int i = 0; i < 5; i++) begin
            if ((4'(i) >= ptr_r) && (4'(i) < ptr_next_s)) begin
                if (bypass_r) begin
                    next_work_s[i] = work_r[i];
                end else begin
                    next_work_s[i] = sigma(3'(i), work_r[i]);
                end
            end else begin
                next_work_s[i] = work_r[i];
            end
        end
    end

    // Handshake FSM, word pointer, working register and registered outputs.
    // With the output register enabled, BUSY spends one extra cycle after the
    // last pass copying the finished state into out_r on the BUSY->DONE edge.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            ptr_r    <= 4'd0;
            work_r   <= '0;
            bypass_r <= 1'b0;
            out_r    <= '0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i) begin
                        work_r   <= diffusion_i;
                        bypass_r <= bypass_i;
                        ptr_r    <= 4'd0;
                        ready_r  <= 1'b0;
                        state_r  <= BUSY;
                    end else begin
                        ready_r  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (ptr_r < WORDS_W) begin
                        work_r <= next_work_s;
                        ptr_r  <= ptr_next_s;
                        if (!USE_OUT_REG && last_pass_s) begin
                            valid_r <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            valid_r <= 1'b0;
                        end
                    end else begin
                        out_r   <= work_r;
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign diffusion_o = USE_OUT_REG ? out_r : work_r;
    assign valid_o     = valid_r;
    assign ready_o     = ready_r;

endmodule

// File: tb/tb_diffusion_layer_seq.sv
// Directed, table-driven bench for diffusion_layer_seq. Five instances with
// different LANES/REG_OUT settings share the same stimulus; each is checked
// for data, latency, hold-in-DONE behaviour and the return to IDLE.

module tb_diffusion_layer_seq;
    import ascon_pack::*;

    localparam int NI = 5;

    logic      clock_i = 1'b0;
    logic      reset_i;
    logic      valid_i;
    logic      bypass_i;
    logic      ready_i;
    type_state diffusion_i;

    logic      ready_o_a [NI];
    logic      valid_o_a [NI];
    type_state dout_a    [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string     nm;
        logic      byp;
        type_state din;
        type_state dexp;
    } vec_t;

    vec_t vecs [11];

    always #5 clock_i = ~clock_i;

    // Instance k uses LANES=k+1; instance 3 (LANES=4) has no output register.
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        diffusion_layer_seq #(
            .LANES  (gi + 1),
            .REG_OUT((gi == 3) ? 0 : 1)
        ) u_dut (
            .clock_i    (clock_i),
            .reset_i    (reset_i),
            .valid_i    (valid_i),
            .ready_o    (ready_o_a[gi]),
            .bypass_i   (bypass_i),
            .diffusion_i(diffusion_i),
            .valid_o    (valid_o_a[gi]),
            .ready_i    (ready_i),
            .diffusion_o(dout_a[gi])
        );
    end

    function automatic type_state mk(input logic [63:0] x0, input logic [63:0] x1,
                                     input logic [63:0] x2, input logic [63:0] x3,
                                     input logic [63:0] x4);
        return {x4, x3, x2, x1, x0};
    endfunction

    // Expected accept-to-valid latency: ceil(5/LANES) passes plus REG_OUT.
    function automatic int exp_lat(input int k);
        int l;
        int r;
        l = k + 1;
        r = (k == 3) ? 0 : 1;
        return ((5 + l - 1) / l) + r;
    endfunction

    task automatic chk_state(input string nm, input int k, input type_state act, input type_state exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%h required=%h", nm, k, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int k, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d actual=%0d required=%0d", nm, k, act, exp);
        end
    endtask

    // One full transaction on all instances, with input noise while busy.
    task automatic run_vec(input vec_t v);
        int lat  [NI];
        bit held [NI];
        diffusion_i = v.din;
        bypass_i    = v.byp;
        valid_i     = 1'b1;
        @(posedge clock_i); #1;
        diffusion_i = ~v.din;
        bypass_i    = ~v.byp;
        for (int k = 0; k < NI; k++) begin
            lat[k]  = 0;
            held[k] = 1'b1;
            chk_int({v.nm, "/ready_busy"}, k, int'(ready_o_a[k]), 0);
        end
        for (int c = 1; c <= 16; c++) begin
            @(posedge clock_i); #1;
            for (int k = 0; k < NI; k++) begin
                if (lat[k] != 0) begin
                    if ((valid_o_a[k] !== 1'b1) || (ready_o_a[k] !== 1'b0) || (dout_a[k] !== v.dexp))
                        held[k] = 1'b0;
                end else if (valid_o_a[k] === 1'b1) begin
                    lat[k] = c;
                    chk_state({v.nm, "/data"}, k, dout_a[k], v.dexp);
                end
            end
        end
        for (int k = 0; k < NI; k++) begin
            chk_int({v.nm, "/latency"}, k, lat[k], exp_lat(k));
            chk_int({v.nm, "/hold"}, k, int'(held[k]), 1);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clock_i); #1;
        ready_i = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk_int({v.nm, "/ready_idle"}, k, int'(ready_o_a[k]), 1);
            chk_int({v.nm, "/valid_low"}, k, int'(valid_o_a[k]), 0);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input logic byp,
                           input type_state din, input type_state dexp);
        vecs[i].nm   = nm;
        vecs[i].byp  = byp;
        vecs[i].din  = din;
        vecs[i].dexp = dexp;
    endtask

    initial begin
        set_vec(0, "zero", 1'b0, '0, '0);
        set_vec(1, "x0_one", 1'b0, mk(64'h1, 64'h0, 64'h0, 64'h0, 64'h0),
                mk(64'h0000_2010_0000_0001, 64'h0, 64'h0, 64'h0, 64'h0));
        set_vec(2, "x1_one", 1'b0, mk(64'h0, 64'h1, 64'h0, 64'h0, 64'h0),
                mk(64'h0, 64'h0000_0000_0200_0009, 64'h0, 64'h0, 64'h0));
        set_vec(3, "x2_one", 1'b0, mk(64'h0, 64'h0, 64'h1, 64'h0, 64'h0),
                mk(64'h0, 64'h0, 64'h8400_0000_0000_0001, 64'h0, 64'h0));
        set_vec(4, "x3_one", 1'b0, mk(64'h0, 64'h0, 64'h0, 64'h1, 64'h0),
                mk(64'h0, 64'h0, 64'h0, 64'h0040_8000_0000_0001, 64'h0));
        set_vec(5, "x4_one", 1'b0, mk(64'h0, 64'h0, 64'h0, 64'h0, 64'h1),
                mk(64'h0, 64'h0, 64'h0, 64'h0, 64'h0200_0000_0080_0001));
        set_vec(6, "all_one", 1'b0, mk(64'h1, 64'h1, 64'h1, 64'h1, 64'h1),
                mk(64'h0000_2010_0000_0001, 64'h0000_0000_0200_0009, 64'h8400_0000_0000_0001,
                   64'h0040_8000_0000_0001, 64'h0200_0000_0080_0001));
        set_vec(7, "all_ff", 1'b0, {5{64'hFFFF_FFFF_FFFF_FFFF}}, {5{64'hFFFF_FFFF_FFFF_FFFF}});
        set_vec(8, "bypass_kat", 1'b1,
                mk(64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7, 64'h4b81c0cbbdb5fc1a,
                   64'hb22e133e424f0250, 64'h044d33702433805d),
                mk(64'h78e2cc41faabaa1a, 64'hbc7a2e775aababf7, 64'h4b81c0cbbdb5fc1a,
                   64'hb22e133e424f0250, 64'h044d33702433805d));
        set_vec(9, "bypass_ones", 1'b1, mk(64'h1, 64'h1, 64'h1, 64'h1, 64'h1),
                mk(64'h1, 64'h1, 64'h1, 64'h1, 64'h1));
        set_vec(10, "x0_msb", 1'b0, mk(64'h8000_0000_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0),
                mk(64'h8000_1008_0000_0000, 64'h0, 64'h0, 64'h0, 64'h0));

        // Reset state.
        reset_i     = 1'b1;
        valid_i     = 1'b0;
        bypass_i    = 1'b0;
        ready_i     = 1'b0;
        diffusion_i = '0;
        #12;
        for (int k = 0; k < NI; k++) begin
            chk_int("rst/ready", k, int'(ready_o_a[k]), 1);
            chk_int("rst/valid", k, int'(valid_o_a[k]), 0);
            chk_state("rst/data", k, dout_a[k], '0);
        end
        @(negedge clock_i);
        reset_i = 1'b0;
        @(posedge clock_i); #1;

        // Table of directed transactions.
        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // Reset asserted during the second BUSY cycle aborts every instance.
        diffusion_i = vecs[7].din;
        bypass_i    = 1'b0;
        valid_i     = 1'b1;
        @(posedge clock_i); #1;
        valid_i = 1'b0;
        @(posedge clock_i); #1;
        reset_i = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk_int("midrst/ready", k, int'(ready_o_a[k]), 1);
            chk_int("midrst/valid", k, int'(valid_o_a[k]), 0);
            chk_state("midrst/data", k, dout_a[k], '0);
        end
        #2;
        reset_i = 1'b0;
        run_vec(vecs[6]);
        run_vec(vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
